// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: IF/ID payload layout, NOP encoding and the
// occupancy states used by the inter-stage skid register.
package cpu_pipe_pkg;

    localparam int PC_W     = 32;
    localparam int INST_W   = 32;
    localparam int PCIM_W   = 12;
    localparam int IFID_W   = PC_W + INST_W + PCIM_W;

    localparam int PC_LSB   = 0;
    localparam int INST_LSB = PC_W;
    localparam int PCIM_LSB = PC_W + INST_W;

    localparam logic [INST_W-1:0] NOP_INST    = 32'h0000_0013;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {IFID_W{1'b0}};

    // Encoding equals the number of entries held, so it drives occ_o directly.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [IFID_W-1:0] ifid_pack(
        input logic [PCIM_W-1:0] pcim,
        input logic [INST_W-1:0] inst,
        input logic [PC_W-1:0]   pc
    );
        return {pcim, inst, pc};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count register, held once the maximum is reached.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid
// buffer, flush-to-bubble and a saturating bubble counter.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int                 DATA_W     = IFID_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                 CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    occ_e              state_r, state_s;
    logic              main_valid_r, main_valid_s;
    logic              skid_valid_r, skid_valid_s;
    logic              in_ready_r, in_ready_s;
    logic [DATA_W-1:0] main_data_r, main_data_s;
    logic [DATA_W-1:0] skid_data_r, skid_data_s;
    logic              accept_s, drain_s;

    assign accept_s = in_valid_i & in_ready_r;
    assign drain_s  = main_valid_r & out_ready_i;

    // Next-state logic; flush overrides everything, a same-cycle drain is already seen downstream.
    always_comb begin
        state_s     = state_r;
        main_data_s = main_data_r;
        skid_data_s = skid_data_r;
        if (flush_i) begin
            state_s     = OCC_EMPTY;
            main_data_s = BUBBLE_VAL;
            skid_data_s = BUBBLE_VAL;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (accept_s) begin
                        state_s     = OCC_ONE;
                        main_data_s = in_data_i;
                    end else begin
                        state_s     = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept_s && drain_s) begin
                        state_s     = OCC_ONE;
                        main_data_s = in_data_i;
                    end else if (accept_s) begin
                        state_s     = OCC_TWO;
                        skid_data_s = in_data_i;
                    end else if (drain_s) begin
                        state_s     = OCC_EMPTY;
                        main_data_s = BUBBLE_VAL;
                    end else begin
                        state_s     = OCC_ONE;
                    end
                end
                OCC_TWO: begin
                    // Skid always refills main, so acceptance order is preserved.
                    if (drain_s) begin
                        state_s     = OCC_ONE;
                        main_data_s = skid_data_r;
                        skid_data_s = BUBBLE_VAL;
                    end else begin
                        state_s     = OCC_TWO;
                    end
                end
                default: begin
                    state_s     = OCC_EMPTY;
                    main_data_s = BUBBLE_VAL;
                    skid_data_s = BUBBLE_VAL;
                end
            endcase
        end
        main_valid_s = (state_s != OCC_EMPTY);
        skid_valid_s = (state_s == OCC_TWO);
        in_ready_s   = (state_s != OCC_TWO);
    end

    // Storage flops; every output is driven straight from these.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_r      <= OCC_EMPTY;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_data_r  <= BUBBLE_VAL;
            skid_data_r  <= BUBBLE_VAL;
        end else begin
            state_r      <= state_s;
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= in_ready_s;
            main_data_r  <= main_data_s;
            skid_data_r  <= skid_data_s;
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = main_valid_r;
    assign out_data_o  = main_data_r;
    assign occ_o       = state_r;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_n (start_i),
        .inc   (out_ready_i & ~main_valid_r),
        .cnt   (bubble_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random
// traffic, compared against a capacity-2 FIFO reference model.
module tb_pipe_stage_skid;
    import cpu_pipe_pkg::*;

    localparam int                DATA_W = IFID_W;
    localparam int                CNT_W  = 3;
    localparam int                CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] BUB    = ifid_pack(12'h000, NOP_INST, 32'h0000_0000);

    logic              clk;
    logic              start_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  bubble_cnt;

    pipe_stage_skid #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i        (clk),
        .start_i      (start_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .flush_i      (flush),
        .occ_o        (occ),
        .bubble_cnt_o (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mq[$];
    int                mcnt;
    logic [DATA_W-1:0] dlog[$];
    int                vectors;
    int                miscompares;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [DATA_W-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : BUB;
        chk("out_valid",  96'(out_valid),  96'(mq.size() > 0));
        chk("out_data",   96'(out_data),   96'(exp_data));
        chk("in_ready",   96'(in_ready),   96'(mq.size() < 2));
        chk("occ",        96'(occ),        96'(mq.size()));
        chk("bubble_cnt", 96'(bubble_cnt), 96'(mcnt));
    endtask

    // One clock of stimulus: check at negedge, drive, then advance the model at posedge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r,
                        input logic f, output logic acc);
        logic drn;
        @(negedge clk);
        check_all();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        if (out_valid && r) dlog.push_back(out_data);
        acc = v && (mq.size() < 2);
        drn = (mq.size() > 0) && r;
        if (r && (mq.size() == 0) && (mcnt < CNT_MAX)) mcnt++;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        start_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        mq.delete();
        mcnt = 0;
        #1;
        check_all();
        @(negedge clk);
        start_n = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom, $urandom, $urandom});
    endfunction

    initial begin
        logic acc;
        int   base;
        logic [DATA_W-1:0] a, b, c;
        vectors     = 0;
        miscompares = 0;
        mcnt        = 0;
        start_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush       = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        start_n = 1'b1;

        // Streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) step(1'b1, DATA_W'(i), 1'b1, 1'b0, acc);
        step(1'b0, BUB, 1'b1, 1'b0, acc);

        // Backpressure: A, B, C with stall
        a = rnd_data(); b = rnd_data(); c = rnd_data();
        base = dlog.size();
        step(1'b1, a, 1'b1, 1'b0, acc);
        step(1'b1, b, 1'b0, 1'b0, acc);
        step(1'b1, c, 1'b0, 1'b0, acc);
        step(1'b1, c, 1'b0, 1'b0, acc);
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) step(1'b1, c, 1'b1, 1'b0, acc);
        chk("c_accepted", 96'(acc), 96'(1'b1));
        repeat (3) step(1'b0, BUB, 1'b1, 1'b0, acc);
        chk("bp_count", 96'(dlog.size()), 96'(base + 3));
        if (dlog.size() == base + 3) begin
            chk("bp_first",  96'(dlog[base]),     96'(a));
            chk("bp_second", 96'(dlog[base + 1]), 96'(b));
            chk("bp_third",  96'(dlog[base + 2]), 96'(c));
        end else begin
            chk("bp_len_ok", 96'(dlog.size()), 96'(base + 3));
        end

        // Flush while full, with an incoming payload and stalled output
        base = dlog.size();
        step(1'b1, rnd_data(), 1'b0, 1'b0, acc);
        step(1'b1, rnd_data(), 1'b0, 1'b0, acc);
        step(1'b1, rnd_data(), 1'b0, 1'b1, acc);
        step(1'b0, BUB, 1'b0, 1'b0, acc);
        repeat (3) step(1'b0, BUB, 1'b1, 1'b0, acc);
        chk("flush_nothing_out", 96'(dlog.size()), 96'(base));

        // Flush coinciding with a drain
        base = dlog.size();
        a = rnd_data();
        step(1'b1, a, 1'b1, 1'b0, acc);
        step(1'b1, rnd_data(), 1'b1, 1'b1, acc);
        repeat (3) step(1'b0, BUB, 1'b1, 1'b0, acc);
        chk("flush_drain_count", 96'(dlog.size()), 96'(base + 1));
        if (dlog.size() > base) chk("flush_drain_data", 96'(dlog[base]), 96'(a));
        else chk("flush_drain_missing", 96'(dlog.size()), 96'(base + 1));

        // Asynchronous reset with two entries held
        step(1'b1, rnd_data(), 1'b0, 1'b0, acc);
        step(1'b1, rnd_data(), 1'b0, 1'b0, acc);
        step(1'b0, BUB, 1'b0, 1'b0, acc);
        do_reset();

        // Bubble counter saturation
        repeat (10) step(1'b0, BUB, 1'b1, 1'b0, acc);
        @(negedge clk);
        chk("bubble_sat", 96'(bubble_cnt), 96'(CNT_MAX));
        do_reset();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rnd_data(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), acc);
        end
        step(1'b0, BUB, 1'b1, 1'b0, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
